gmii_rx_axis_packer: RTL and testbench

Receive-side counterpart of the AXIS-to-GMII transmit path in the DPE Ethernet subsystem. Takes raw GMII bytes (one per clk), strips preamble/SFD and FCS, and checks the CRC-32. Packs the payload little-endian into 128-bit AXI-Stream words with tkeep, tlast and a bad-frame tuser bit. Feeds the DPE ingress at the gtx_clk rate, with no MAC FIFO in between.

---
 rtl/gmii_rx_axis_packer.sv | 191 +++++++++++++++++++
 tb/tb_gmii_rx_axis_packer.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gmii_rx_axis_packer.sv
// gmii_rx_axis_packer: strips preamble/SFD and FCS from GMII receive bytes,
// checks CRC-32, and packs the payload little-endian into AXI-Stream words
// with byte enables, end-of-frame marking and a bad-frame user bit.
module gmii_rx_axis_packer #(
    parameter int DATA_WIDTH    = 128,
    parameter int MIN_FRAME_LEN = 64,
    parameter int CHECK_FCS     = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [7:0]                gmii_rxd,
    input  logic                      gmii_rx_dv,
    input  logic                      gmii_rx_er,
    output logic [DATA_WIDTH-1:0]     m_axis_tdata,
    output logic [DATA_WIDTH/8-1:0]   m_axis_tkeep,
    output logic                      m_axis_tvalid,
    input  logic                      m_axis_tready,
    output logic                      m_axis_tlast,
    output logic                      m_axis_tuser,
    output logic                      stat_good_frame,
    output logic                      stat_bad_fcs,
    output logic                      stat_bad_frame,
    output logic                      stat_overflow
);
    localparam int          LANES       = DATA_WIDTH / 8;
    localparam logic [10:0] LEN_MAX     = 11'd2047;
    localparam logic [31:0] CRC_RESIDUE = 32'hC704DD7B;

    typedef enum logic [2:0] {IDLE, PREAMBLE, PAYLOAD, DROP, FLUSH} state_t;

    state_t                state;
    logic [31:0]           crc;
    logic [31:0]           dly;
    logic [2:0]            dly_n;
    logic [10:0]           len;
    logic [DATA_WIDTH-1:0] pack;
    logic [4:0]            pack_n;
    logic                  er_flag;
    logic                  ovf_flag;

    logic                  out_free;
    logic                  fcs_bad;
    logic                  marker;
    logic                  flush_user;
    logic [LANES-1:0]      flush_keep;
    logic [7:0]            dly_out;

    // Reflected (LSB-first) CRC-32, one byte per call.
    function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c ^ {24'h0, d};
        for (int unsigned i = 0; i < 8; i++) begin
            r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
        end
        return r;
    endfunction

    // The register is kept in reflected form; the residue constant is in
    // MSB-first form, so compare against the bit-reversed register.
    function automatic logic [31:0] bitrev32(input logic [31:0] c);
        logic [31:0] r;
        for (int unsigned i = 0; i < 32; i++) begin
            r[i] = c[31-i];
        end
        return r;
    endfunction

    // Frame-start decode shared by IDLE, PREAMBLE and the FLUSH exit.
    function automatic state_t idle_next(input logic dv, input logic [7:0] d);
        if (!dv)              return IDLE;
        else if (d == 8'h55)  return PREAMBLE;
        else if (d == 8'hD5)  return PAYLOAD;
        else                  return DROP;
    endfunction

    // End-of-frame status and output-register availability.
    always_comb begin
        out_free   = !m_axis_tvalid || m_axis_tready;
        fcs_bad    = bitrev32(crc) != CRC_RESIDUE;
        marker     = ovf_flag || (len <= 11'd4);
        flush_user = ((CHECK_FCS != 0) && fcs_bad) || er_flag ||
                     (len < 11'(MIN_FRAME_LEN)) || ovf_flag;
        flush_keep = '0;
        for (int unsigned i = 0; i < LANES; i++) begin
            flush_keep[i] = (5'(i) < pack_n);
        end
        dly_out    = dly[7:0];
    end

    // Receive FSM, delay line, packer and registered AXIS/stat outputs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state           <= IDLE;
            crc             <= '1;
            dly             <= '0;
            dly_n           <= '0;
            len             <= '0;
            pack            <= '0;
            pack_n          <= '0;
            er_flag         <= 1'b0;
            ovf_flag        <= 1'b0;
            m_axis_tdata    <= '0;
            m_axis_tkeep    <= '0;
            m_axis_tvalid   <= 1'b0;
            m_axis_tlast    <= 1'b0;
            m_axis_tuser    <= 1'b0;
            stat_good_frame <= 1'b0;
            stat_bad_fcs    <= 1'b0;
            stat_bad_frame  <= 1'b0;
            stat_overflow   <= 1'b0;
        end else begin
            stat_good_frame <= m_axis_tvalid && m_axis_tready && m_axis_tlast && !m_axis_tuser;
            stat_bad_frame  <= m_axis_tvalid && m_axis_tready && m_axis_tlast && m_axis_tuser;
            stat_bad_fcs    <= 1'b0;
            stat_overflow   <= 1'b0;
            if (m_axis_tvalid && m_axis_tready) begin
                m_axis_tvalid <= 1'b0;
            end

            case (state)
                IDLE, PREAMBLE: begin
                    state <= idle_next(gmii_rx_dv, gmii_rxd);
                end

                PAYLOAD: begin
                    if (gmii_rx_dv) begin
                        crc <= crc_byte(crc, gmii_rxd);
                        dly <= {gmii_rxd, dly[31:8]};
                        if (len != LEN_MAX) len <= len + 11'd1;
                        if (gmii_rx_er) er_flag <= 1'b1;
                        if (dly_n != 3'd4) begin
                            dly_n <= dly_n + 3'd1;
                        end else if (pack_n == 5'(LANES)) begin
                            // A full word is held back until the next payload
                            // byte proves it is not the frame's last word.
                            if (out_free) begin
                                m_axis_tdata  <= pack;
                                m_axis_tkeep  <= '1;
                                m_axis_tlast  <= 1'b0;
                                m_axis_tuser  <= 1'b0;
                                m_axis_tvalid <= 1'b1;
                                pack          <= {{(DATA_WIDTH-8){1'b0}}, dly_out};
                                pack_n        <= 5'd1;
                            end else begin
                                stat_overflow <= 1'b1;
                                ovf_flag      <= 1'b1;
                                state         <= DROP;
                            end
                        end else begin
                            pack[{pack_n[3:0], 3'b000} +: 8] <= dly_out;
                            pack_n <= pack_n + 5'd1;
                        end
                    end else begin
                        stat_bad_fcs <= (CHECK_FCS != 0) && fcs_bad;
                        state        <= FLUSH;
                    end
                end

                DROP: begin
                    if (!gmii_rx_dv) state <= ovf_flag ? FLUSH : IDLE;
                end

                FLUSH: begin
                    if (out_free) begin
                        if (marker) begin
                            m_axis_tdata <= '0;
                            m_axis_tkeep <= {{(LANES-1){1'b0}}, 1'b1};
                            m_axis_tuser <= 1'b1;
                        end else begin
                            m_axis_tdata <= pack;
                            m_axis_tkeep <= flush_keep;
                            m_axis_tuser <= flush_user;
                        end
                        m_axis_tlast  <= 1'b1;
                        m_axis_tvalid <= 1'b1;
                        crc           <= '1;
                        dly_n         <= '0;
                        len           <= '0;
                        pack          <= '0;
                        pack_n        <= '0;
                        er_flag       <= 1'b0;
                        ovf_flag      <= 1'b0;
                        state         <= idle_next(gmii_rx_dv, gmii_rxd);
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_gmii_rx_axis_packer.sv
// tb_gmii_rx_axis_packer: scoreboard bench for the GMII receive packer.
`timescale 1ns/1ps
module tb_gmii_rx_axis_packer;
    localparam int MIN_LEN = 64;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [7:0]   gmii_rxd = '0;
    logic         gmii_rx_dv = 1'b0;
    logic         gmii_rx_er = 1'b0;
    logic [127:0] m_axis_tdata;
    logic [15:0]  m_axis_tkeep;
    logic         m_axis_tvalid;
    logic         m_axis_tready = 1'b1;
    logic         m_axis_tlast;
    logic         m_axis_tuser;
    logic         stat_good_frame, stat_bad_fcs, stat_bad_frame, stat_overflow;

    gmii_rx_axis_packer #(
        .DATA_WIDTH   (128),
        .MIN_FRAME_LEN(MIN_LEN),
        .CHECK_FCS    (1)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .gmii_rxd       (gmii_rxd),
        .gmii_rx_dv     (gmii_rx_dv),
        .gmii_rx_er     (gmii_rx_er),
        .m_axis_tdata   (m_axis_tdata),
        .m_axis_tkeep   (m_axis_tkeep),
        .m_axis_tvalid  (m_axis_tvalid),
        .m_axis_tready  (m_axis_tready),
        .m_axis_tlast   (m_axis_tlast),
        .m_axis_tuser   (m_axis_tuser),
        .stat_good_frame(stat_good_frame),
        .stat_bad_fcs   (stat_bad_fcs),
        .stat_bad_frame (stat_bad_frame),
        .stat_overflow  (stat_overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [127:0] data;
        logic [15:0]  keep;
        logic         last;
        logic         user;
    } word_t;

    word_t      exp_q[$];
    logic [7:0] fb[$];
    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int tready_mode = 0;
    int n_good = 0, n_fcs = 0, n_bad = 0, n_ovf = 0;
    int g0, f0, b0, o0;
    int tlast_rise_cyc = -1;
    int dv_fall_cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [159:0] got, input logic [159:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] crc_step(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c ^ {24'h0, d};
        for (int i = 0; i < 8; i++) r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
        return r;
    endfunction

    // Payload of n bytes (start + i*step) followed by its FCS, LSB byte first.
    task automatic make_frame(input logic [7:0] start, input logic [7:0] step, input int n);
        logic [31:0] r;
        logic [7:0]  b;
        fb.delete();
        r = '1;
        for (int i = 0; i < n; i++) begin
            b = start + 8'(i) * step;
            fb.push_back(b);
            r = crc_step(r, b);
        end
        r = ~r;
        for (int i = 0; i < 4; i++) fb.push_back(r[8*i +: 8]);
    endtask

    // Expected words for the bytes in fb (everything after the SFD).
    task automatic push_expected(input logic er, output logic bad_fcs, output logic good);
        word_t w;
        int    flen, npay;
        logic  [31:0] r;
        logic  user;
        flen = fb.size();
        r = '1;
        foreach (fb[i]) r = crc_step(r, fb[i]);
        bad_fcs = (r != 32'hDEBB20E3);
        if (flen <= 4) begin
            w.data = '0; w.keep = 16'h0001; w.last = 1'b1; w.user = 1'b1;
            exp_q.push_back(w);
            good = 1'b0;
        end else begin
            user = bad_fcs | er | (flen < MIN_LEN);
            npay = flen - 4;
            for (int base = 0; base < npay; base += 16) begin
                w.data = '0; w.keep = '0;
                for (int j = 0; j < 16 && base + j < npay; j++) begin
                    w.data[8*j +: 8] = fb[base+j];
                    w.keep[j] = 1'b1;
                end
                w.last = (base + 16 >= npay);
                w.user = w.last & user;
                exp_q.push_back(w);
            end
            good = !user;
        end
    endtask

    task automatic send_frame(input int ifg, input int er_idx);
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            gmii_rx_dv = 1'b1; gmii_rx_er = 1'b0;
            gmii_rxd = (i == 7) ? 8'hD5 : 8'h55;
        end
        foreach (fb[i]) begin
            @(posedge clk); #1;
            gmii_rxd = fb[i];
            gmii_rx_er = (i == er_idx);
        end
        @(posedge clk); #1;
        gmii_rx_dv = 1'b0; gmii_rx_er = 1'b0; gmii_rxd = '0;
        dv_fall_cyc = cyc;
        repeat (ifg - 1) @(posedge clk);
    endtask

    task automatic wait_drain(input int budget);
        int k = 0;
        while (exp_q.size() != 0 && k < budget) begin
            @(posedge clk);
            k++;
        end
        check("drain_timeout", 160'(exp_q.size()), 0);
        repeat (4) @(posedge clk);
    endtask

    task automatic snap();
        g0 = n_good; f0 = n_fcs; b0 = n_bad; o0 = n_ovf;
    endtask

    task automatic check_stats(input string tag, input int eg, input int ef, input int eb, input int eo);
        check({tag, "_stat_good"},     n_good - g0, eg);
        check({tag, "_stat_bad_fcs"},  n_fcs - f0,  ef);
        check({tag, "_stat_bad_frame"}, n_bad - b0, eb);
        check({tag, "_stat_overflow"}, n_ovf - o0,  eo);
    endtask

    // tready pattern generator.
    initial begin
        forever begin
            @(posedge clk); #1;
            case (tready_mode)
                1:       m_axis_tready = (cyc % 3 == 0);
                2:       m_axis_tready = 1'b0;
                default: m_axis_tready = 1'b1;
            endcase
        end
    end

    // Output monitor: scoreboard pops, AXIS stability and stat pulse counts.
    word_t        mw;
    logic [127:0] mask;
    logic         prev_stall = 1'b0;
    logic         prev_vl = 1'b0;
    logic [145:0] held;
    always @(negedge clk) begin
        if (rst) begin
            if (prev_stall)
                check("axis_stable", {m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tuser}, held);
            if (m_axis_tvalid && m_axis_tready) begin
                if (exp_q.size() == 0) begin
                    check("extra_word", 160'(exp_q.size()), 1);
                end else begin
                    mw = exp_q.pop_front();
                    for (int j = 0; j < 16; j++) mask[8*j +: 8] = {8{mw.keep[j]}};
                    check("tdata", m_axis_tdata & mask, mw.data & mask);
                    check("tkeep", m_axis_tkeep, mw.keep);
                    check("tlast", m_axis_tlast, mw.last);
                    check("tuser", m_axis_tlast & m_axis_tuser, mw.last & mw.user);
                end
            end
            if (m_axis_tvalid && m_axis_tlast && !prev_vl) tlast_rise_cyc = cyc;
            prev_vl    = m_axis_tvalid && m_axis_tlast;
            prev_stall = m_axis_tvalid && !m_axis_tready;
            held       = {m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tuser};
            n_good += int'(stat_good_frame);
            n_fcs  += int'(stat_bad_fcs);
            n_bad  += int'(stat_bad_frame);
            n_ovf  += int'(stat_overflow);
        end else begin
            prev_stall = 1'b0;
            prev_vl    = 1'b0;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached with %0d words outstanding", exp_q.size());
        $fatal(1, "watchdog");
    end

    initial begin
        logic  bf, gd, bf2, gd2;
        word_t ow;

        rst = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_tvalid", m_axis_tvalid, 0);
        check("rst_tdata",  m_axis_tdata, 0);
        check("rst_tkeep",  m_axis_tkeep, 0);
        check("rst_tlast_tuser", {m_axis_tlast, m_axis_tuser}, 0);
        check("rst_stats", {stat_good_frame, stat_bad_fcs, stat_bad_frame, stat_overflow}, 0);
        @(posedge clk); #1 rst = 1'b1;
        repeat (3) @(posedge clk);

        // Good 60-byte frame, latency to tlast.
        snap();
        make_frame(8'h00, 8'h01, 60);
        push_expected(1'b0, bf, gd);
        send_frame(12, -1);
        wait_drain(100);
        check("t1_tlast_latency", tlast_rise_cyc - dv_fall_cyc, 2);
        check_stats("t1", int'(gd), int'(bf), int'(!gd), 0);

        // Corrupted byte, then a good frame after a 1-cycle IFG.
        snap();
        make_frame(8'h00, 8'h01, 60);
        fb[5] = fb[5] ^ 8'h01;
        push_expected(1'b0, bf, gd);
        send_frame(1, -1);
        make_frame(8'h00, 8'h01, 60);
        push_expected(1'b0, bf2, gd2);
        send_frame(12, -1);
        wait_drain(200);
        check_stats("t2", int'(gd) + int'(gd2), int'(bf) + int'(bf2),
                    int'(!gd) + int'(!gd2), 0);

        // 164-byte payload with tready high one cycle in three.
        snap();
        tready_mode = 1;
        make_frame(8'hA2, 8'h07, 164);
        push_expected(1'b0, bf, gd);
        send_frame(12, -1);
        wait_drain(400);
        tready_mode = 0;
        check_stats("t3", int'(gd), int'(bf), int'(!gd), 0);

        // Runt with payload, then a 3-byte frame.
        snap();
        make_frame(8'h30, 8'h03, 20);
        push_expected(1'b0, bf, gd);
        send_frame(12, -1);
        wait_drain(100);
        fb.delete();
        fb.push_back(8'h11); fb.push_back(8'h22); fb.push_back(8'h33);
        push_expected(1'b0, bf2, gd2);
        send_frame(12, -1);
        wait_drain(100);
        check_stats("t4", int'(gd) + int'(gd2), int'(bf) + int'(bf2),
                    int'(!gd) + int'(!gd2), 0);

        // rx_er inside an otherwise good frame.
        snap();
        make_frame(8'h40, 8'h01, 60);
        push_expected(1'b1, bf, gd);
        send_frame(12, 10);
        wait_drain(100);
        check_stats("t_er", int'(gd), int'(bf), int'(!gd), 0);

        // Overflow: 128-byte frame with tready low throughout.
        snap();
        tready_mode = 2;
        make_frame(8'h80, 8'h01, 124);
        ow.data = '0; ow.keep = 16'hFFFF; ow.last = 1'b0; ow.user = 1'b0;
        for (int j = 0; j < 16; j++) ow.data[8*j +: 8] = fb[j];
        exp_q.push_back(ow);
        ow.data = '0; ow.keep = 16'h0001; ow.last = 1'b1; ow.user = 1'b1;
        exp_q.push_back(ow);
        send_frame(12, -1);
        repeat (5) @(posedge clk);
        tready_mode = 0;
        wait_drain(100);
        check_stats("t5", 0, 0, 1, 1);

        // Reset mid-payload, then a clean frame.
        snap();
        make_frame(8'h10, 8'h01, 70);
        for (int i = 0; i < 18; i++) begin
            @(posedge clk); #1;
            gmii_rx_dv = 1'b1;
            gmii_rxd = (i < 7) ? 8'h55 : (i == 7) ? 8'hD5 : fb[i-8];
        end
        @(posedge clk); #1;
        rst = 1'b0; gmii_rx_dv = 1'b0; gmii_rxd = '0;
        @(posedge clk); #1 rst = 1'b1;
        @(negedge clk);
        check("t6_rst_tvalid", m_axis_tvalid, 0);
        check("t6_rst_tdata", m_axis_tdata, 0);
        check("t6_rst_tkeep_tlast_tuser", {m_axis_tkeep, m_axis_tlast, m_axis_tuser}, 0);
        repeat (3) @(posedge clk);
        push_expected(1'b0, bf, gd);
        send_frame(12, -1);
        wait_drain(100);
        check_stats("t6", int'(gd), int'(bf), int'(!gd), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
